// File: rtl/lcd_panel_responder.sv
// Panel-side responder for the four-chip 256x64 graphic LCD bus: decodes E-strobe
// transactions into per-chip controller state, a 2 KiB frame memory and bus read data.
module lcd_panel_responder #(
  parameter int unsigned CHIPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_rst_i,
  input  logic             en_i,
  input  logic             dori_i,
  input  logic             rw_i,
  input  logic [CHIPS-1:0] cs_i,
  input  logic [7:0]       db_i,
  output logic [7:0]       db_o,
  output logic             db_oe_o,
  output logic [CHIPS-1:0] disp_on_o,
  output logic             wr_stb_o,
  input  logic [10:0]      rd_addr_i,
  output logic [7:0]       rd_data_o
);

  localparam int unsigned CW    = 2;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 2048;

  logic             r_en_q;
  logic             r_cap_dori;
  logic             r_cap_rw;
  logic [CHIPS-1:0] r_cap_cs;
  logic [7:0]       r_cap_db;
  logic [7:0]       r_db_o;
  logic             r_db_oe;
  logic             r_wr_stb;
  logic [7:0]       r_rd_data;

  logic [CHIPS-1:0][5:0] r_y;
  logic [CHIPS-1:0][2:0] r_page;
  logic [CHIPS-1:0][5:0] r_start;
  logic [CHIPS-1:0]      r_on;
  logic [CHIPS-1:0]      r_rst_flag;
  logic [CHIPS-1:0][7:0] r_latch;

  logic [7:0] r_mem [0:DEPTH-1];

  logic [CHIPS-1:0][5:0] w_y_nxt;
  logic [CHIPS-1:0][2:0] w_page_nxt;
  logic [CHIPS-1:0][5:0] w_start_nxt;
  logic [CHIPS-1:0]      w_on_nxt;
  logic [CHIPS-1:0][7:0] w_latch_nxt;
  logic [CHIPS-1:0]      w_wr_en;
  logic                  w_commit;
  logic [CW-1:0]         w_lo_cap;
  logic [CW-1:0]         w_lo_live;
  logic [7:0]            w_status;
  logic                  w_rd_active;

  function automatic logic [CW-1:0] f_lowest(input logic [CHIPS-1:0] cs);
    f_lowest = '0;
    for (int i = int'(CHIPS) - 1; i >= 0; i--) begin
      if (cs[i]) f_lowest = CW'(i);
    end
  endfunction

  // A captured transaction executes once on the E falling edge, unless held in reset.
  assign w_commit    = ~rst & ~lcd_rst_i & r_en_q & ~en_i & (|r_cap_cs);
  assign w_lo_cap    = f_lowest(r_cap_cs);
  assign w_lo_live   = f_lowest(cs_i);
  assign w_rd_active = en_i & rw_i & (|cs_i);
  assign w_status    = {2'b00, ~r_on[w_lo_live], r_rst_flag[w_lo_live], 4'b0000};

  // Per-chip next state for instruction, data write and dummy-read commits.
  always_comb begin
    w_y_nxt     = r_y;
    w_page_nxt  = r_page;
    w_start_nxt = r_start;
    w_on_nxt    = r_on;
    w_latch_nxt = r_latch;
    w_wr_en     = '0;
    if (w_commit) begin
      for (int c = 0; c < int'(CHIPS); c++) begin
        if (r_cap_cs[c]) begin
          if (!r_cap_dori && !r_cap_rw) begin
            casez (r_cap_db)
              8'b0011111?: w_on_nxt[c]    = r_cap_db[0];
              8'b01??????: w_y_nxt[c]     = r_cap_db[5:0];
              8'b10111???: w_page_nxt[c]  = r_cap_db[2:0];
              8'b11??????: w_start_nxt[c] = r_cap_db[5:0];
              default: ;
            endcase
          end else if (r_cap_dori && !r_cap_rw) begin
            w_wr_en[c] = 1'b1;
            w_y_nxt[c] = r_y[c] + 6'd1;
          end else if (r_cap_dori && r_cap_rw && (w_lo_cap == CW'(c))) begin
            w_latch_nxt[c] = r_mem[{CW'(c), r_page[c], r_y[c]}];
            w_y_nxt[c]     = r_y[c] + 6'd1;
          end
        end
      end
    end
  end

  // Chip controller registers; panel reset clears everything but the read latches.
  always_ff @(posedge clk) begin
    if (rst || lcd_rst_i) begin
      r_y        <= '0;
      r_page     <= '0;
      r_start    <= '0;
      r_on       <= '0;
      r_rst_flag <= '1;
    end else begin
      r_y        <= w_y_nxt;
      r_page     <= w_page_nxt;
      r_start    <= w_start_nxt;
      r_on       <= w_on_nxt;
      r_rst_flag <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_latch <= '0;
    else     r_latch <= w_latch_nxt;
  end

  // Bus capture, edge tracking and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q     <= 1'b0;
      r_cap_dori <= 1'b0;
      r_cap_rw   <= 1'b0;
      r_cap_cs   <= '0;
      r_cap_db   <= '0;
      r_db_o     <= '0;
      r_db_oe    <= 1'b0;
      r_wr_stb   <= 1'b0;
    end else begin
      r_en_q <= en_i & ~lcd_rst_i;
      if (en_i) begin
        r_cap_dori <= dori_i;
        r_cap_rw   <= rw_i;
        r_cap_cs   <= cs_i;
        r_cap_db   <= db_i;
      end
      r_db_oe  <= w_rd_active;
      r_db_o   <= w_rd_active ? (dori_i ? r_latch[w_lo_live] : w_status) : 8'h00;
      r_wr_stb <= w_commit & r_cap_dori & ~r_cap_rw;
    end
  end

  // Frame memory is never cleared; the scan port reads before a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= r_mem[rd_addr_i];
    for (int c = 0; c < int'(CHIPS); c++) begin
      if (w_wr_en[c]) r_mem[AW'({CW'(c), r_page[c], r_y[c]})] <= r_cap_db;
    end
  end

  assign db_o      = r_db_o;
  assign db_oe_o   = r_db_oe;
  assign disp_on_o = r_on;
  assign wr_stb_o  = r_wr_stb;
  assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Directed, table-driven bench for lcd_panel_responder: bus transactions with
// expected display/strobe/read values, then frame-port and reset corner cases.
module tb_lcd_panel_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_rst_i;
  logic       en_i;
  logic       dori_i;
  logic       rw_i;
  logic [3:0] cs_i;
  logic [7:0] db_i;
  logic [7:0] db_o;
  logic       db_oe_o;
  logic [3:0] disp_on_o;
  logic       wr_stb_o;
  logic [10:0] rd_addr_i;
  logic [7:0] rd_data_o;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt = 0;

  lcd_panel_responder #(.CHIPS(4)) dut (
    .clk(clk), .rst(rst), .lcd_rst_i(lcd_rst_i), .en_i(en_i), .dori_i(dori_i),
    .rw_i(rw_i), .cs_i(cs_i), .db_i(db_i), .db_o(db_o), .db_oe_o(db_oe_o),
    .disp_on_o(disp_on_o), .wr_stb_o(wr_stb_o), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb_o) stb_cnt++;

  typedef struct {
    logic       dori;
    logic       rw;
    logic [3:0] cs;
    logic [7:0] db;
    logic       chk_db;
    logic [7:0] exp_db;
    logic [3:0] exp_disp;
    logic       exp_stb;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic dori, input logic rw, input logic [3:0] cs,
                              input logic [7:0] db, input logic chk_db,
                              input logic [7:0] exp_db, input logic [3:0] exp_disp,
                              input logic exp_stb);
    vec_t v;
    v.dori = dori; v.rw = rw; v.cs = cs; v.db = db; v.chk_db = chk_db;
    v.exp_db = exp_db; v.exp_disp = exp_disp; v.exp_stb = exp_stb;
    return v;
  endfunction

  function automatic logic [10:0] fa(input int c, input int p, input int y);
    return 11'(c * 512 + p * 64 + y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One E high cycle then one E low cycle; returns db_o/db_oe_o seen while E is high.
  task automatic txn(input logic dori, input logic rw, input logic [3:0] cs,
                     input logic [7:0] db, output logic [7:0] rd, output logic oe);
    en_i = 1'b1; dori_i = dori; rw_i = rw; cs_i = cs; db_i = db;
    tick();
    rd = db_o;
    oe = db_oe_o;
    en_i = 1'b0;
    tick();
  endtask

  task automatic fread(input logic [10:0] a, output logic [7:0] d);
    rd_addr_i = a;
    tick();
    d = rd_data_o;
  endtask

  logic [7:0] rd;
  logic       oe;
  int         stb_ref;

  initial begin
    vecs[0]  = mk(0, 0, 4'b0001, 8'hBB, 0, 8'h00, 4'b0000, 0);
    vecs[1]  = mk(0, 0, 4'b0001, 8'h7E, 0, 8'h00, 4'b0000, 0);
    vecs[2]  = mk(1, 0, 4'b0001, 8'hAA, 0, 8'h00, 4'b0000, 1);
    vecs[3]  = mk(1, 0, 4'b0001, 8'h55, 0, 8'h00, 4'b0000, 1);
    vecs[4]  = mk(1, 0, 4'b0001, 8'h0F, 0, 8'h00, 4'b0000, 1);
    vecs[5]  = mk(0, 0, 4'b1111, 8'h3F, 0, 8'h00, 4'b1111, 0);
    vecs[6]  = mk(0, 0, 4'b0100, 8'h3E, 0, 8'h00, 4'b1011, 0);
    vecs[7]  = mk(0, 0, 4'b0001, 8'h00, 0, 8'h00, 4'b1011, 0);
    vecs[8]  = mk(1, 0, 4'b0000, 8'h77, 0, 8'h00, 4'b1011, 0);
    vecs[9]  = mk(1, 0, 4'b0001, 8'h99, 0, 8'h00, 4'b1011, 1);
    vecs[10] = mk(0, 1, 4'b0100, 8'h00, 1, 8'h20, 4'b1011, 0);
    vecs[11] = mk(0, 1, 4'b0010, 8'h00, 1, 8'h00, 4'b1011, 0);
    vecs[12] = mk(0, 0, 4'b0100, 8'hB8, 0, 8'h00, 4'b1011, 0);
    vecs[13] = mk(0, 0, 4'b0100, 8'h40, 0, 8'h00, 4'b1011, 0);
    vecs[14] = mk(1, 0, 4'b0100, 8'h5A, 0, 8'h00, 4'b1011, 1);
    vecs[15] = mk(0, 0, 4'b0100, 8'h40, 0, 8'h00, 4'b1011, 0);
    vecs[16] = mk(1, 1, 4'b0100, 8'h00, 1, 8'h00, 4'b1011, 0);
    vecs[17] = mk(1, 1, 4'b0100, 8'h00, 1, 8'h5A, 4'b1011, 0);
    vecs[18] = mk(1, 0, 4'b0100, 8'hC3, 0, 8'h00, 4'b1011, 1);
    vecs[19] = mk(1, 0, 4'b0011, 8'h66, 0, 8'h00, 4'b1011, 1);

    rst = 1'b1; lcd_rst_i = 1'b0; en_i = 1'b0; dori_i = 1'b0; rw_i = 1'b0;
    cs_i = 4'b0000; db_i = 8'h00; rd_addr_i = '0;
    tick();
    tick();
    chk("reset_db_o", 32'(db_o), 32'h00);
    chk("reset_db_oe", 32'(db_oe_o), 32'h0);
    chk("reset_disp_on", 32'(disp_on_o), 32'h0);
    chk("reset_wr_stb", 32'(wr_stb_o), 32'h0);
    chk("reset_rd_data", 32'(rd_data_o), 32'h00);
    rst = 1'b0;
    tick();

    // Status read of chip 0 while the panel reset is held, then after release.
    lcd_rst_i = 1'b1;
    tick();
    txn(0, 1, 4'b0001, 8'h00, rd, oe);
    chk("status_in_lcd_rst", 32'(rd), 32'h30);
    chk("status_oe", 32'(oe), 32'h1);
    lcd_rst_i = 1'b0;
    tick();
    txn(0, 1, 4'b0001, 8'h00, rd, oe);
    chk("status_after_lcd_rst", 32'(rd), 32'h20);

    stb_ref = stb_cnt;
    for (int i = 0; i < 20; i++) begin
      txn(vecs[i].dori, vecs[i].rw, vecs[i].cs, vecs[i].db, rd, oe);
      chk($sformatf("v%0d_disp_on", i), 32'(disp_on_o), 32'(vecs[i].exp_disp));
      chk($sformatf("v%0d_wr_stb", i), 32'(wr_stb_o), 32'(vecs[i].exp_stb));
      chk($sformatf("v%0d_db_oe", i), 32'(oe), 32'(vecs[i].rw & (|vecs[i].cs)));
      if (vecs[i].chk_db) chk($sformatf("v%0d_db_o", i), 32'(rd), 32'(vecs[i].exp_db));
    end
    tick();
    chk("wr_stb_pulses", 32'(stb_cnt - stb_ref), 32'd7);

    fread(fa(0, 3, 62), rd); chk("mem_0_3_62", 32'(rd), 32'hAA);
    fread(fa(0, 3, 63), rd); chk("mem_0_3_63", 32'(rd), 32'h55);
    fread(fa(0, 3, 0), rd);  chk("mem_0_3_0_wrap", 32'(rd), 32'h0F);
    fread(fa(0, 3, 1), rd);  chk("mem_0_3_1_after_illegal", 32'(rd), 32'h99);
    fread(fa(2, 0, 0), rd);  chk("mem_2_0_0", 32'(rd), 32'h5A);
    fread(fa(2, 0, 2), rd);  chk("mem_2_0_2_y_after_reads", 32'(rd), 32'hC3);
    fread(fa(0, 3, 2), rd);  chk("mem_bcast_chip0", 32'(rd), 32'h66);
    fread(fa(1, 0, 0), rd);  chk("mem_bcast_chip1", 32'(rd), 32'h66);

    // Panel reset asserted while a data write to {0,3,62} is pending.
    txn(0, 0, 4'b0001, 8'h7E, rd, oe);
    stb_ref = stb_cnt;
    en_i = 1'b1; dori_i = 1'b1; rw_i = 1'b0; cs_i = 4'b0001; db_i = 8'hEE;
    tick();
    lcd_rst_i = 1'b1;
    tick();
    en_i = 1'b0;
    tick();
    lcd_rst_i = 1'b0;
    tick();
    tick();
    chk("midrst_no_stb", 32'(stb_cnt - stb_ref), 32'd0);
    chk("midrst_disp_off", 32'(disp_on_o), 32'h0);
    fread(fa(0, 3, 62), rd); chk("midrst_mem_kept", 32'(rd), 32'hAA);
    fread(fa(0, 3, 63), rd); chk("midrst_mem_kept2", 32'(rd), 32'h55);
    txn(1, 0, 4'b0001, 8'h33, rd, oe);
    fread(fa(0, 0, 0), rd);  chk("midrst_y_page_zero", 32'(rd), 32'h33);

    // Scan port read-before-write on the commit edge of a write to the same address.
    txn(0, 0, 4'b0001, 8'h40, rd, oe);
    rd_addr_i = fa(0, 0, 0);
    en_i = 1'b1; dori_i = 1'b1; rw_i = 1'b0; cs_i = 4'b0001; db_i = 8'h44;
    tick();
    en_i = 1'b0;
    tick();
    chk("rbw_old_data", 32'(rd_data_o), 32'h33);
    tick();
    chk("rbw_new_data", 32'(rd_data_o), 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
